fifo_read_ctrl: RTL

- Read-side controller for the team's 8-entry x 32-bit FIFO; counterpart of the write-enable decode path.
- Owns the head (read) pointer, the occupancy count and the empty/full flags, and registers the dequeued word.
- Sits between the FIFO register file (flattened 8-word bus) and the consumer; the write side signals each accepted write with a one-cycle commit pulse.

---
 rtl/fifo_read_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the 8 x 32-bit FIFO.
// Owns the head pointer, occupancy count and empty/full flags, and
// registers the dequeued word for the consumer.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          re,
  input  logic                          wr_commit,
  input  logic [DEPTH*DATA_WIDTH-1:0]   rf_data,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          rd_ack,
  output logic                          rd_err,
  output logic                          empty,
  output logic                          full,
  output logic [ADDR_WIDTH:0]           data_count
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    NO_OP    = 2'd1,
    READ     = 2'd2,
    RD_ERROR = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  state_t                  state;
  logic [ADDR_WIDTH:0]     count;
  logic [DATA_WIDTH-1:0]   words [DEPTH];
  logic                    accept;
  logic                    write_ok;

  // Unpack the flattened register-file bus into an indexable word array.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unpack
    assign words[gi] = rf_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // A read is only accepted against the registered count; a same-edge
  // commit never bypasses into an empty FIFO. Commits into a full FIFO
  // are dropped so the count cannot overflow.
  always_comb begin
    accept   = re && (count != '0);
    write_ok = wr_commit && (count != FULL_COUNT);
  end

  // State, pointer, count and dequeued data, all updated on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT;
      rd_addr <= '0;
      count   <= '0;
      dout    <= '0;
      rd_ack  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      if (accept) begin
        state   <= READ;
        dout    <= words[rd_addr];
        rd_addr <= rd_addr + ADDR_ONE;
      end else if (re) begin
        state <= RD_ERROR;
      end else begin
        state <= NO_OP;
      end
      rd_ack <= accept;
      rd_err <= re && !accept;

      // Read and write on the same edge cancel out.
      if (accept && !wr_commit) begin
        count <= count - COUNT_ONE;
      end else if (!accept && write_ok) begin
        count <= count + COUNT_ONE;
      end
    end
  end

  // Flags decode straight off the registered count.
  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_COUNT);
    data_count = count;
  end

endmodule
